// File: rtl/pio_in_debounce_edge_if.sv
// Avalon-MM slave bus bundle for the PIO input block: register select, write strobe/data and registered read data.
interface pio_in_debounce_edge_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_in_debounce_edge.sv
// Debounced PIO input with per-bit edge enables, W1C edge capture, maskable irq and saturating event counter.
// Reads return one cycle after address is presented; writes complete in one cycle with no backpressure.
module pio_in_debounce_edge #(
    parameter int                WIDTH      = 4,
    parameter int                CNT_W      = 16,
    parameter int                EVT_W      = 16,
    parameter logic [CNT_W-1:0]  DB_RESET   = '0,
    parameter logic [WIDTH-1:0]  RISE_RESET = '0,
    parameter logic [WIDTH-1:0]  FALL_RESET = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_in_debounce_edge_if.slave bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam logic [CNT_W:0]   CNT_ONE_X = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [EVT_W-1:0] EVT_ONE   = 1;

    logic [WIDTH-1:0] sync1, sync2, stable, stable_d, stable_nxt;
    logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en, det, clr;
    logic [CNT_W-1:0] db_thresh;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [EVT_W-1:0] evt_cnt;
    logic [31:0]      rd_nxt;
    logic             wr;
    logic             unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // A bit commits once it has differed for db_thresh consecutive compares; 0 and 1 both commit at once.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (({1'b0, cnt[i]} + CNT_ONE_X) >= {1'b0, db_thresh})
                    stable_nxt[i] = sync2[i];
                else
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    assign det = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
    assign clr = (wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;
    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        rd_nxt = '0;
        case (bus.address)
            3'd0: rd_nxt[WIDTH-1:0] = stable;
            3'd1: rd_nxt[WIDTH-1:0] = sync2;
            3'd2: rd_nxt[WIDTH-1:0] = irq_mask;
            3'd3: rd_nxt[WIDTH-1:0] = edge_capture;
            3'd4: rd_nxt[WIDTH-1:0] = rise_en;
            3'd5: rd_nxt[WIDTH-1:0] = fall_en;
            3'd6: rd_nxt[CNT_W-1:0] = db_thresh;
            3'd7: rd_nxt[EVT_W-1:0] = evt_cnt;
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            stable       <= '0;
            stable_d     <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            evt_cnt      <= '0;
            bus.readdata <= '0;
            db_thresh    <= DB_RESET;
            rise_en      <= RISE_RESET;
            fall_en      <= FALL_RESET;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1        <= in_port;
            sync2        <= sync1;
            stable       <= stable_nxt;
            stable_d     <= stable;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
            // New detections win over a same-cycle clear.
            edge_capture <= (edge_capture & ~clr) | det;
            bus.readdata <= rd_nxt;

            if (wr && bus.address == 3'd2) irq_mask  <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == 3'd4) rise_en   <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == 3'd5) fall_en   <= bus.writedata[WIDTH-1:0];
            if (wr && bus.address == 3'd6) db_thresh <= bus.writedata[CNT_W-1:0];

            if (wr && bus.address == 3'd7)
                evt_cnt <= (|det) ? EVT_ONE : '0;
            else if ((|det) && (evt_cnt != '1))
                evt_cnt <= evt_cnt + EVT_ONE;
        end
    end
endmodule
